mem_lsu: RTL and testbench

//  Load/store initiator for the core's data memory: turns one RV32I load/store request into

---
 rtl/mem_lsu_pkg.sv | 30 +++
 rtl/mem_lsu_load_align.sv | 27 ++
 rtl/mem_lsu.sv | 166 ++++++++++++++++
 tb/tb_mem_lsu.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the mem_lsu load/store initiator: funct3 codes, FSM states, byte-mask width.
package mem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int MASK_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STORE,
        S_LD_ISSUE,
        S_LD_WAIT,
        S_LD_RESP,
        S_ERR
    } lsu_state_t;

    // Stores have no unsigned variants, so BU/HU are only legal for loads.
    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !is_store;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_load_align.sv
// Combinational load extractor: picks the byte/half selected by lane and sign- or zero-extends it.
module mem_lsu_load_align
    import mem_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{lane, 3'b000} +: 8];
        // Halfwords only ever sit in the low or high half; lane[0] is irrelevant here.
        half_sel = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'b0, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'b0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// RV32I load/store initiator driving a bram_sdp with 1-cycle registered read latency.
// Optional misalignment/illegal trap reporting on resp_error: define MEM_LSU_MISALIGN_TRAP_EN.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter  int DEPTH      = 256,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic                  mem_write_enable,
    output logic [MASK_W-1:0]     mem_mask_write,
    output logic [ADDR_WIDTH-1:0] mem_addr_write,
    output logic [31:0]           mem_data_in,
    output logic                  mem_read_enable,
    output logic [ADDR_WIDTH-1:0] mem_addr_read,
    input  logic [31:0]           mem_data_out
);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    // Handshake: a request transfers on the rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and the request fields are sampled on that edge only.
    lsu_state_t state, state_d;

    logic [2:0]            cap_funct3, cap_funct3_d;
    logic [1:0]            cap_lane, cap_lane_d;
    logic                  we_d, re_d, rv_d, err_d;
    logic [MASK_W-1:0]     mask_d;
    logic [ADDR_WIDTH-1:0] waddr_d, raddr_d;
    logic [31:0]           din_d, rdata_d;

    logic                  handshake;
    logic [1:0]            lane;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  legal;
    logic                  misaligned;
    logic [MASK_W-1:0]     store_mask;
    logic [31:0]           store_data;
    logic [31:0]           load_result;
    logic                  unused_addr_hi;

    assign req_ready      = (state == S_IDLE);
    assign handshake      = req_valid && req_ready;
    assign lane           = req_addr[1:0];
    assign word_addr      = req_addr[ADDR_WIDTH+1:2];
    assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];
    assign legal          = f3_legal(req_write, req_funct3);
    assign misaligned     = TRAP_EN &&
                            ((((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && lane[0]) ||
                             ((req_funct3 == F3_W) && (lane != 2'b00)));

    always_comb begin
        store_mask = '1;
        store_data = req_wdata;
        case (req_funct3)
            F3_B: begin
                store_mask = MASK_W'(4'b0001 << lane);
                store_data = {4{req_wdata[7:0]}};
            end
            F3_H: begin
                store_mask = MASK_W'(4'b0011 << {lane[1], 1'b0});
                store_data = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    mem_lsu_load_align u_load_align (
        .word   (mem_data_out),
        .lane   (cap_lane),
        .funct3 (cap_funct3),
        .result (load_result)
    );

    always_comb begin
        state_d      = state;
        cap_funct3_d = cap_funct3;
        cap_lane_d   = cap_lane;
        we_d         = 1'b0;
        mask_d       = '0;
        waddr_d      = '0;
        din_d        = '0;
        re_d         = 1'b0;
        raddr_d      = '0;
        rv_d         = 1'b0;
        rdata_d      = '0;
        err_d        = 1'b0;
        case (state)
            S_IDLE: begin
                if (handshake) begin
                    cap_funct3_d = req_funct3;
                    cap_lane_d   = lane;
                    if (!legal || misaligned) begin
                        state_d = S_ERR;
                        rv_d    = 1'b1;
                        err_d   = TRAP_EN;
                    end else if (req_write) begin
                        state_d = S_STORE;
                        we_d    = 1'b1;
                        mask_d  = store_mask;
                        waddr_d = word_addr;
                        din_d   = store_data;
                        rv_d    = 1'b1;
                    end else begin
                        state_d = S_LD_ISSUE;
                        re_d    = 1'b1;
                        raddr_d = word_addr;
                    end
                end
            end
            S_LD_ISSUE: state_d = S_LD_WAIT;
            // mem_data_out is valid here; capture the aligned result for next cycle's response.
            S_LD_WAIT: begin
                state_d = S_LD_RESP;
                rv_d    = 1'b1;
                rdata_d = load_result;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            cap_funct3       <= '0;
            cap_lane         <= '0;
            mem_write_enable <= 1'b0;
            mem_mask_write   <= '0;
            mem_addr_write   <= '0;
            mem_data_in      <= '0;
            mem_read_enable  <= 1'b0;
            mem_addr_read    <= '0;
            resp_valid       <= 1'b0;
            resp_rdata       <= '0;
            resp_error       <= 1'b0;
        end else begin
            state            <= state_d;
            cap_funct3       <= cap_funct3_d;
            cap_lane         <= cap_lane_d;
            mem_write_enable <= we_d;
            mem_mask_write   <= mask_d;
            mem_addr_write   <= waddr_d;
            mem_data_in      <= din_d;
            mem_read_enable  <= re_d;
            mem_addr_read    <= raddr_d;
            resp_valid       <= rv_d;
            resp_rdata       <= rdata_d;
            resp_error       <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu paired with a behavioural synchronous-read byte-masked memory.
module tb_mem_lsu;

    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_write;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr, req_wdata;
    logic          resp_valid, resp_error;
    logic [31:0]   resp_rdata;
    logic          mem_write_enable, mem_read_enable;
    logic [3:0]    mem_mask_write;
    logic [AW-1:0] mem_addr_write, mem_addr_read;
    logic [31:0]   mem_data_in, mem_data_out;

    int n_vec = 0;
    int n_err = 0;
    int edge_cnt = 0;

    // expectation queues: {edge, error, rdata}, {edge, mask, addr, data}, {edge, addr}
    logic [64:0] exp_q[$];
    logic [75:0] wr_q[$];
    logic [39:0] rd_q[$];

    logic [7:0]  ref_mem [DEPTH*4];
    logic [31:0] bram [DEPTH];

    always #5 clock = ~clock;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    mem_lsu #(.DEPTH(DEPTH)) dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_write_enable (mem_write_enable),
        .mem_mask_write   (mem_mask_write),
        .mem_addr_write   (mem_addr_write),
        .mem_data_in      (mem_data_in),
        .mem_read_enable  (mem_read_enable),
        .mem_addr_read    (mem_addr_read),
        .mem_data_out     (mem_data_out)
    );

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old_w;
        for (int j = 0; j < 4; j++)
            if (mask[j]) r[8*j +: 8] = new_w[8*j +: 8];
        return r;
    endfunction

    always @(posedge clock) begin
        if (mem_write_enable)
            bram[mem_addr_write] <= merge(bram[mem_addr_write], mem_data_in, mem_mask_write);
        if (mem_read_enable)
            mem_data_out <= bram[mem_addr_read];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: byte-addressed memory, access size from funct3, offset from address.
    task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int hs);
        int          size, off, base;
        bit          legal, mis;
        logic [3:0]  mask;
        logic [31:0] din, res;
        logic [AW-1:0] word;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        legal = (size != 0) && !(wr && f3[2]);
        off   = int'(addr[1:0]);
        mis   = (size == 2 && off % 2 != 0) || (size == 4 && off != 0);
        word  = AW'((addr >> 2) % DEPTH);
        base  = int'(word) * 4;
        if (!legal || (TRAP && mis)) begin
            exp_q.push_back({32'(hs), TRAP, 32'h0});
        end else begin
            off = off - off % size;
            if (wr) begin
                mask = 4'b0;
                for (int i = 0; i < size; i++) begin
                    mask[off + i] = 1'b1;
                    ref_mem[base + off + i] = wd[8*i +: 8];
                end
                for (int j = 0; j < 4; j++) din[8*j +: 8] = wd[8*(j % size) +: 8];
                wr_q.push_back({32'(hs), mask, word, din});
                exp_q.push_back({32'(hs), 1'b0, 32'h0});
            end else begin
                res = 32'h0;
                for (int i = 0; i < size; i++)
                    res = res | (32'(ref_mem[base + off + i]) << (8 * i));
                if (!f3[2] && size < 4 && res[8*size-1])
                    res = res | (32'hFFFF_FFFF << (8 * size));
                rd_q.push_back({32'(hs), word});
                exp_q.push_back({32'(hs + 2), 1'b0, res});
            end
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a response or a memory access.
    always @(negedge clock) begin
        if (!reset) begin
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL resp_unexpected: got resp_valid=1 rdata=0x%0h, required no response", resp_rdata);
                end else begin
                    logic [64:0] e;
                    e = exp_q.pop_front();
                    chk("resp_edge", 64'(edge_cnt), 64'(e[64:33]));
                    chk("resp_data", {31'b0, resp_error, resp_rdata}, {31'b0, e[32:0]});
                end
            end
            if (mem_write_enable) begin
                if (wr_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL write_unexpected: got write_enable=1 addr=0x%0h, required none", mem_addr_write);
                end else begin
                    logic [75:0] w;
                    w = wr_q.pop_front();
                    chk("wr_edge", 64'(edge_cnt), 64'(w[75:44]));
                    chk("wr_mask", 64'(mem_mask_write), 64'(w[43:40]));
                    chk("wr_addr", 64'(mem_addr_write), 64'(w[39:32]));
                    chk("wr_data", 64'(mem_data_in), 64'(w[31:0]));
                end
            end
            if (mem_read_enable) begin
                if (rd_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL read_unexpected: got read_enable=1 addr=0x%0h, required none", mem_addr_read);
                end else begin
                    logic [39:0] r;
                    r = rd_q.pop_front();
                    chk("rd_edge", 64'(edge_cnt), 64'(r[39:8]));
                    chk("rd_addr", 64'(mem_addr_read), 64'(r[7:0]));
                end
            end
        end
    end

    // Drives one request and leaves req_valid high; returns the handshake edge index.
    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int hs);
        int waited;
        waited = 0;
        @(negedge clock);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        while (!req_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (!req_ready) begin
            hs = -1;
            n_vec++; n_err++;
            $display("FAIL req_ready: stuck at 0 for 20 cycles, required 1");
            req_valid = 1'b0;
        end else begin
            hs = edge_cnt + 1;
            model(wr, f3, addr, wd, hs);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic expect_resp(input string name, input logic err, input logic [31:0] data);
        bit seen;
        seen = 1'b0;
        req_valid = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clock);
            if (resp_valid) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++; n_err++;
            $display("FAIL %s: resp_valid stayed 0 for 8 cycles, required 1", name);
        end else begin
            chk({name, "_data"}, 64'(resp_rdata), 64'(data));
            chk({name, "_err"}, 64'(resp_error), 64'(err));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, hs2;
        logic [2:0] legal_f3 [5];
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr, wd, hi;
        int          word;
        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < DEPTH * 4; i++) ref_mem[i] = 8'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        chk("rst_resp_error", 64'(resp_error), 64'd0);
        chk("rst_we", 64'(mem_write_enable), 64'd0);
        chk("rst_re", 64'(mem_read_enable), 64'd0);
        chk("rst_mask", 64'(mem_mask_write), 64'd0);
        reset = 1'b0;

        // Clear the whole memory through the DUT so bench memory and model agree.
        for (int i = 0; i < DEPTH; i++) issue(1'b1, 3'b010, 32'(i * 4), 32'h0, hs);

        issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, hs);
        req_valid = 1'b0;
        @(negedge clock);
        chk("sw_we", 64'(mem_write_enable), 64'd1);
        chk("sw_mask", 64'(mem_mask_write), 64'hF);
        chk("sw_waddr", 64'(mem_addr_write), 64'd4);
        issue(1'b0, 3'b010, 32'h10, 32'h0, hs);
        expect_resp("lw_10", 1'b0, 32'hDEAD_BEEF);

        issue(1'b1, 3'b000, 32'h13, 32'h80, hs);
        req_valid = 1'b0;
        @(negedge clock);
        chk("sb_mask", 64'(mem_mask_write), 64'b1000);
        issue(1'b0, 3'b000, 32'h13, 32'h0, hs);
        expect_resp("lb_13", 1'b0, 32'hFFFF_FF80);
        issue(1'b0, 3'b100, 32'h13, 32'h0, hs);
        expect_resp("lbu_13", 1'b0, 32'h0000_0080);

        issue(1'b1, 3'b001, 32'h22, 32'h8001, hs);
        req_valid = 1'b0;
        @(negedge clock);
        chk("sh_mask", 64'(mem_mask_write), 64'b1100);
        chk("sh_din", 64'(mem_data_in), 64'h8001_8001);
        issue(1'b0, 3'b001, 32'h22, 32'h0, hs);
        expect_resp("lh_22", 1'b0, 32'hFFFF_8001);
        issue(1'b0, 3'b101, 32'h22, 32'h0, hs);
        expect_resp("lhu_22", 1'b0, 32'h0000_8001);

        issue(1'b1, 3'b010, 32'h0, 32'h1234_5678, hs);
        issue(1'b0, 3'b010, 32'h402, 32'h0, hs);
        if (TRAP) begin
            req_valid = 1'b0;
            @(negedge clock);
            chk("lw_402_valid", 64'(resp_valid), 64'd1);
            chk("lw_402_error", 64'(resp_error), 64'd1);
            chk("lw_402_re", 64'(mem_read_enable), 64'd0);
        end else begin
            expect_resp("lw_402", 1'b0, 32'h1234_5678);
        end

        issue(1'b0, 3'b011, 32'h10, 32'h0, hs);
        req_valid = 1'b0;
        @(negedge clock);
        chk("ill_valid", 64'(resp_valid), 64'd1);
        chk("ill_rdata", 64'(resp_rdata), 64'd0);
        chk("ill_error", 64'(resp_error), 64'(TRAP));
        chk("ill_re", 64'(mem_read_enable), 64'd0);
        chk("ill_we", 64'(mem_write_enable), 64'd0);

        // Reset while the load sits in LD_WAIT: response must never appear.
        issue(1'b0, 3'b010, 32'h10, 32'h0, hs);
        req_valid = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("ldrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("ldrst_req_ready", 64'(req_ready), 64'd1);
        chk("ldrst_re", 64'(mem_read_enable), 64'd0);
        exp_q.delete();
        rd_q.delete();
        wr_q.delete();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("ldrst_ready_after", 64'(req_ready), 64'd1);
        chk("ldrst_no_resp", 64'(resp_valid), 64'd0);
        repeat (4) @(negedge clock);

        // Back-to-back with req_valid held high.
        issue(1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, hs);
        issue(1'b0, 3'b010, 32'h30, 32'h0, hs2);
        chk("b2b_gap", 64'(hs2 - hs), 64'd2);
        expect_resp("b2b_lw", 1'b0, 32'hCAFE_F00D);

        for (int i = 0; i < 400; i++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8) f3 = legal_f3[$urandom_range(0, 4)];
            else f3 = 3'($urandom_range(0, 7));
            word = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
            hi   = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FC00) : 32'h0;
            addr = hi | 32'(word << 2) | 32'($urandom_range(0, 3));
            wd   = $urandom;
            issue(wr, f3, addr, wd, hs);
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 4)) @(posedge clock);
                #1;
            end
        end
        req_valid = 1'b0;

        for (int k = 0; k < 50 && (exp_q.size() + wr_q.size() + rd_q.size()) != 0; k++)
            @(negedge clock);
        @(negedge clock);
        chk("drain_resp", 64'(exp_q.size()), 64'd0);
        chk("drain_write", 64'(wr_q.size()), 64'd0);
        chk("drain_read", 64'(rd_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
